// File: rtl/framebuffer_pkg.sv
// Shared framebuffer geometry, pixel format and arbiter state encoding.
package framebuffer_pkg;

   localparam int FB_W       = 128;
   localparam int FB_H       = 128;
   localparam int COORD_W    = 7;
   localparam int PIXEL_W    = 16;
   localparam int FB_PIXELS  = FB_W * FB_H;

   // Fill counter walks the screen x-fastest: low bits are x, high bits are y.
   localparam int FILL_X_W   = $clog2(FB_W);
   localparam int FILL_Y_W   = $clog2(FB_H);
   localparam int FILL_CNT_W = $clog2(FB_PIXELS);

   typedef enum logic {
      ARB  = 1'b0,
      FILL = 1'b1
   } arb_state_t;

endpackage

// File: rtl/fb_fill_counter.sv
// Clear-screen pixel counter: advances once per granted fill write and
// splits its value into an (x, y) coordinate.
module fb_fill_counter
   import framebuffer_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               advance,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               last
);

   logic [FILL_CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clear) begin
         cnt_reg <= '0;
      end else if (advance) begin
         cnt_reg <= cnt_reg + FILL_CNT_W'(1);
      end
   end

   assign x    = cnt_reg[FILL_X_W-1:0];
   assign y    = cnt_reg[FILL_X_W +: FILL_Y_W];
   assign last = (cnt_reg == FILL_CNT_W'(FB_PIXELS - 1));

endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer arbiter: scanout reads win over writes, with a
// starvation bound, and a built-in clear-screen fill engine.
module framebuffer_arbiter
   import framebuffer_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rd_req,
   input  logic [COORD_W-1:0] rd_x,
   input  logic [COORD_W-1:0] rd_y,
   output logic               rd_gnt,
   output logic [PIXEL_W-1:0] rd_data,
   output logic               rd_valid,
   input  logic               wr_req,
   input  logic [COORD_W-1:0] wr_x,
   input  logic [COORD_W-1:0] wr_y,
   input  logic [PIXEL_W-1:0] wr_data,
   output logic               wr_gnt,
   input  logic               fill_start,
   input  logic [PIXEL_W-1:0] fill_color,
   output logic               fill_busy,
   output logic               mem_rd_en,
   output logic               mem_wr_en,
   output logic [COORD_W-1:0] mem_rd_addr_x,
   output logic [COORD_W-1:0] mem_rd_addr_y,
   output logic [COORD_W-1:0] mem_wr_addr_x,
   output logic [COORD_W-1:0] mem_wr_addr_y,
   output logic [PIXEL_W-1:0] mem_data_in,
   input  logic [PIXEL_W-1:0] mem_data_out,
   input  logic               mem_valid_out
);

   localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

   arb_state_t         state_reg;
   logic [SC_W-1:0]    starve_cnt_reg;
   logic [SC_W-1:0]    starve_cnt_next;
   logic [PIXEL_W-1:0] fill_color_reg;
   logic               fill_busy_reg;

   logic               mem_rd_en_reg;
   logic               mem_wr_en_reg;
   logic [COORD_W-1:0] mem_rd_addr_x_reg;
   logic [COORD_W-1:0] mem_rd_addr_y_reg;
   logic [COORD_W-1:0] mem_wr_addr_x_reg;
   logic [COORD_W-1:0] mem_wr_addr_y_reg;
   logic [PIXEL_W-1:0] mem_data_in_reg;
   logic               rd_inflight_reg;
   logic               rd_valid_reg;
   logic [PIXEL_W-1:0] rd_data_reg;

   logic               wr_pending;
   logic               starved;
   logic               rd_grant;
   logic               wr_grant;
   logic               fill_grant;
   logic               fill_accept;
   logic               fill_last;
   logic [COORD_W-1:0] fill_x;
   logic [COORD_W-1:0] fill_y;

   // In FILL the fill engine always has a write pending; client writes wait.
   always_comb begin
      wr_pending  = (state_reg == FILL) ? 1'b1 : wr_req;
      starved     = wr_pending && (starve_cnt_reg >= STARVE_MAX);
      rd_grant    = rst_n && rd_req && !starved;
      wr_grant    = rst_n && wr_pending && !rd_grant;
      fill_grant  = wr_grant && (state_reg == FILL);
      fill_accept = fill_start && (state_reg == ARB);

      starve_cnt_next = starve_cnt_reg;
      if (wr_grant || !wr_pending) begin
         starve_cnt_next = '0;
      end else if (rd_grant) begin
         starve_cnt_next = starve_cnt_reg + SC_W'(1);
      end
   end

   assign rd_gnt = rd_grant;
   assign wr_gnt = wr_grant && (state_reg == ARB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ARB;
         fill_busy_reg  <= 1'b0;
         fill_color_reg <= '0;
         starve_cnt_reg <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
         case (state_reg)
            ARB: begin
               if (fill_start) begin
                  state_reg      <= FILL;
                  fill_busy_reg  <= 1'b1;
                  fill_color_reg <= fill_color;
               end
            end
            FILL: begin
               if (fill_grant && fill_last) begin
                  state_reg     <= ARB;
                  fill_busy_reg <= 1'b0;
               end
            end
         endcase
      end
   end

   // Granted transaction is presented to memory one cycle after its grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rd_en_reg     <= 1'b0;
         mem_wr_en_reg     <= 1'b0;
         mem_rd_addr_x_reg <= '0;
         mem_rd_addr_y_reg <= '0;
         mem_wr_addr_x_reg <= '0;
         mem_wr_addr_y_reg <= '0;
         mem_data_in_reg   <= '0;
      end else begin
         mem_rd_en_reg <= rd_grant;
         mem_wr_en_reg <= wr_grant;
         if (rd_grant) begin
            mem_rd_addr_x_reg <= rd_x;
            mem_rd_addr_y_reg <= rd_y;
         end
         if (wr_grant) begin
            if (state_reg == FILL) begin
               mem_wr_addr_x_reg <= fill_x;
               mem_wr_addr_y_reg <= fill_y;
               mem_data_in_reg   <= fill_color_reg;
            end else begin
               mem_wr_addr_x_reg <= wr_x;
               mem_wr_addr_y_reg <= wr_y;
               mem_data_in_reg   <= wr_data;
            end
         end
      end
   end

   // Only accept memory data for a read issued since reset, so reads in
   // flight across a reset never produce rd_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_inflight_reg <= 1'b0;
         rd_valid_reg    <= 1'b0;
         rd_data_reg     <= '0;
      end else begin
         rd_inflight_reg <= mem_rd_en_reg;
         rd_valid_reg    <= mem_valid_out && rd_inflight_reg;
         if (mem_valid_out && rd_inflight_reg) begin
            rd_data_reg <= mem_data_out;
         end
      end
   end

   fb_fill_counter u_fill_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (fill_accept),
      .advance (fill_grant),
      .x       (fill_x),
      .y       (fill_y),
      .last    (fill_last)
   );

   assign fill_busy     = fill_busy_reg;
   assign mem_rd_en     = mem_rd_en_reg;
   assign mem_wr_en     = mem_wr_en_reg;
   assign mem_rd_addr_x = mem_rd_addr_x_reg;
   assign mem_rd_addr_y = mem_rd_addr_y_reg;
   assign mem_wr_addr_x = mem_wr_addr_x_reg;
   assign mem_wr_addr_y = mem_wr_addr_y_reg;
   assign mem_data_in   = mem_data_in_reg;
   assign rd_valid      = rd_valid_reg;
   assign rd_data       = rd_data_reg;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Scoreboard bench for framebuffer_arbiter: stimulus pushes expected memory
// and read-return transactions, a negedge monitor pops and compares them.
module tb_framebuffer_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_req;
   logic [6:0]  rd_x, rd_y;
   logic        rd_gnt;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        wr_req;
   logic [6:0]  wr_x, wr_y;
   logic [15:0] wr_data;
   logic        wr_gnt;
   logic        fill_start;
   logic [15:0] fill_color;
   logic        fill_busy;
   logic        mem_rd_en, mem_wr_en;
   logic [6:0]  mem_rd_addr_x, mem_rd_addr_y, mem_wr_addr_x, mem_wr_addr_y;
   logic [15:0] mem_data_in;
   logic [15:0] mem_data_out = 16'h0000;
   logic        mem_valid_out = 1'b0;

   int vectors     = 0;
   int miscompares = 0;
   int wr_seen     = 0;
   int base;
   logic done;
   logic hit;

   logic [29:0] wr_q[$];
   logic [13:0] mrd_q[$];
   logic [15:0] rdv_q[$];
   logic [29:0] exp_wr;
   logic [13:0] exp_rd;
   logic [15:0] exp_rdv;

   always #5 clk = ~clk;

   framebuffer_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rd_req        (rd_req),
      .rd_x          (rd_x),
      .rd_y          (rd_y),
      .rd_gnt        (rd_gnt),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .wr_req        (wr_req),
      .wr_x          (wr_x),
      .wr_y          (wr_y),
      .wr_data       (wr_data),
      .wr_gnt        (wr_gnt),
      .fill_start    (fill_start),
      .fill_color    (fill_color),
      .fill_busy     (fill_busy),
      .mem_rd_en     (mem_rd_en),
      .mem_wr_en     (mem_wr_en),
      .mem_rd_addr_x (mem_rd_addr_x),
      .mem_rd_addr_y (mem_rd_addr_y),
      .mem_wr_addr_x (mem_wr_addr_x),
      .mem_wr_addr_y (mem_wr_addr_y),
      .mem_data_in   (mem_data_in),
      .mem_data_out  (mem_data_out),
      .mem_valid_out (mem_valid_out)
   );

   function automatic logic [15:0] mem_val(input logic [6:0] x, input logic [6:0] y);
      if (x == 7'd5 && y == 7'd9) return 16'h1234;
      return {2'b00, x, y};
   endfunction

   // Memory model: one-cycle read latency.
   always @(posedge clk) begin
      mem_valid_out <= mem_rd_en;
      mem_data_out  <= mem_val(mem_rd_addr_x, mem_rd_addr_y);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every memory strobe and read return is matched against the queues.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_rd_en || mem_wr_en)
            check("one_strobe", 32'(mem_rd_en & mem_wr_en), 32'd0);
         if (mem_wr_en) begin
            wr_seen++;
            check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
               exp_wr = wr_q.pop_front();
               check("mem_wr", 32'({mem_wr_addr_x, mem_wr_addr_y, mem_data_in}), 32'(exp_wr));
            end
         end
         if (mem_rd_en) begin
            check("rd_expected", 32'(mrd_q.size() != 0), 32'd1);
            if (mrd_q.size() != 0) begin
               exp_rd = mrd_q.pop_front();
               check("mem_rd", 32'({mem_rd_addr_x, mem_rd_addr_y}), 32'(exp_rd));
            end
         end
         if (rd_valid) begin
            check("rdv_expected", 32'(rdv_q.size() != 0), 32'd1);
            if (rdv_q.size() != 0) begin
               exp_rdv = rdv_q.pop_front();
               check("rd_data", 32'(rd_data), 32'(exp_rdv));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      rd_req = 1'b1; rd_x = 7'd0; rd_y = 7'd0;
      wr_req = 1'b1; wr_x = 7'd0; wr_y = 7'd0; wr_data = 16'h0000;
      fill_start = 1'b1; fill_color = 16'hFFFF;
      #12;
      check("reset_gnt", 32'({rd_gnt, wr_gnt}), 32'd0);
      check("reset_ctrl", 32'({mem_rd_en, mem_wr_en, fill_busy, rd_valid}), 32'd0);
      check("reset_rd_data", 32'(rd_data), 32'd0);
      check("reset_mem_data", 32'(mem_data_in), 32'd0);
      rd_req = 1'b0; wr_req = 1'b0; fill_start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Single read (5,9): grant T, strobe T+1, rd_valid T+3.
      @(posedge clk); #1;
      rd_req = 1'b1; rd_x = 7'd5; rd_y = 7'd9;
      mrd_q.push_back({7'd5, 7'd9});
      rdv_q.push_back(16'h1234);
      @(negedge clk);
      check("rd_gnt", 32'({rd_gnt, wr_gnt}), 32'b10);
      @(posedge clk); #1;
      rd_req = 1'b0;
      @(negedge clk);
      check("rd_strobe_t1", 32'(mem_rd_en), 32'd1);
      @(negedge clk);
      check("rd_valid_t2", 32'(rd_valid), 32'd0);
      @(negedge clk);
      check("rd_valid_t3", 32'(rd_valid), 32'd1);

      // Single write (127,127) F800: same-cycle grant, strobe T+1.
      @(posedge clk); #1;
      wr_req = 1'b1; wr_x = 7'd127; wr_y = 7'd127; wr_data = 16'hF800;
      wr_q.push_back({7'd127, 7'd127, 16'hF800});
      @(negedge clk);
      check("wr_gnt", 32'({rd_gnt, wr_gnt}), 32'b01);
      @(posedge clk); #1;
      wr_req = 1'b0;
      @(negedge clk);
      check("wr_strobe_t1", 32'(mem_wr_en), 32'd1);

      // Reads and writes both held: R,R,R,R,W repeating.
      @(posedge clk); #1;
      rd_req = 1'b1; rd_x = 7'd3; rd_y = 7'd4;
      wr_req = 1'b1; wr_x = 7'd10; wr_y = 7'd20; wr_data = 16'hABCD;
      for (int i = 0; i < 10; i++) begin
         logic [1:0] exp_g;
         exp_g = (i % 5 == 4) ? 2'b01 : 2'b10;
         if (exp_g[1]) begin
            mrd_q.push_back({7'd3, 7'd4});
            rdv_q.push_back(16'h0184);
         end else begin
            wr_q.push_back({7'd10, 7'd20, 16'hABCD});
         end
         @(negedge clk);
         check("starve_pattern", 32'({rd_gnt, wr_gnt}), 32'(exp_g));
         @(posedge clk); #1;
      end
      rd_req = 1'b0; wr_req = 1'b0;
      repeat (4) @(posedge clk);

      // fill_start together with a client write, then full-screen fill.
      wr_q.push_back({7'd1, 7'd2, 16'h5555});
      for (int i = 0; i < 16384; i++) begin
         logic [13:0] c;
         c = 14'(i);
         wr_q.push_back({c[6:0], c[13:7], 16'h001F});
      end
      wr_q.push_back({7'd9, 7'd9, 16'h0F0F});
      base = wr_seen;
      #1;
      @(posedge clk); #1;
      fill_start = 1'b1; fill_color = 16'h001F;
      wr_req = 1'b1; wr_x = 7'd1; wr_y = 7'd2; wr_data = 16'h5555;
      @(negedge clk);
      check("fill_start_wr_gnt", 32'({wr_gnt, fill_busy}), 32'b10);
      @(posedge clk); #1;
      fill_start = 1'b0; fill_color = 16'h0000; wr_req = 1'b0;
      @(negedge clk);
      check("fill_busy_rise", 32'({fill_busy, mem_wr_en}), 32'b11);
      done = 1'b0;
      for (int i = 0; i < 17000 && !done; i++) begin
         @(posedge clk); #1;
         if (i == 10) begin
            wr_req = 1'b1; wr_x = 7'd9; wr_y = 7'd9; wr_data = 16'h0F0F;
         end
         fill_start = (i == 50);
         if (i == 50) fill_color = 16'h07E0;
         @(negedge clk);
         if (fill_busy) begin
            check("fill_wr_gnt", 32'(wr_gnt), 32'd0);
         end else begin
            check("fill_end", 32'({mem_wr_en, wr_gnt}), 32'b11);
            done = 1'b1;
         end
      end
      check("fill_done", 32'(done), 32'd1);
      @(posedge clk); #1;
      wr_req = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("fill_write_count", 32'(wr_seen - base), 32'd16386);

      // Reset while the fill counter sits at 100.
      for (int i = 0; i < 100; i++) begin
         logic [6:0] c7;
         c7 = 7'(i);
         wr_q.push_back({c7, 7'd0, 16'hFFFF});
      end
      base = wr_seen;
      @(posedge clk); #1;
      fill_start = 1'b1; fill_color = 16'hFFFF;
      @(posedge clk); #1;
      fill_start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(negedge clk); #1;
         if (wr_seen - base >= 100) hit = 1'b1;
      end
      check("fill_progress", 32'(hit), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_ctrl", 32'({mem_wr_en, mem_rd_en, fill_busy, wr_gnt, rd_gnt, rd_valid}), 32'd0);
      check("rst_wr_path", 32'({mem_wr_addr_x, mem_wr_addr_y, mem_data_in}), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      check("post_rst_busy", 32'(fill_busy), 32'd0);
      check("post_rst_writes", 32'(wr_seen - base), 32'd100);
      check("queues_empty", 32'(wr_q.size() + mrd_q.size() + rdv_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/framebuffer_arbiter.md
FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, maximum consecutive read grants while any write is pending.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low. Ports listed in REQ-003..REQ-023.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 rd_req  in  1  scanout read request; held until granted.
REQ-006 rd_x, rd_y  in  7 each  read pixel coordinate.
REQ-007 rd_gnt  out  1  combinational; read accepted this cycle.
REQ-008 rd_data  out  16  read pixel, RGB565.
REQ-009 rd_valid  out  1  rd_data valid, one-cycle pulse per granted read.
REQ-010 wr_req  in  1  drawing-client write request; held until granted.
REQ-011 wr_x, wr_y  in  7 each  write pixel coordinate.
REQ-012 wr_data  in  16  write pixel.
REQ-013 wr_gnt  out  1  combinational; client write accepted this cycle.
REQ-014 fill_start  in  1  single-cycle pulse: start a clear-screen fill.
REQ-015 fill_color  in  16  fill pixel; sampled on the accepted fill_start.
REQ-016 fill_busy  out  1  fill in progress.
REQ-017 mem_rd_en, mem_wr_en  out  1 each  registered memory strobes.
REQ-018 mem_rd_addr_x, mem_rd_addr_y  out  7 each  registered read address.
REQ-019 mem_wr_addr_x, mem_wr_addr_y  out  7 each  registered write address.
REQ-020 mem_data_in  out  16  registered write data.
REQ-021 mem_data_out  in  16  memory read data.
REQ-022 mem_valid_out  in  1  memory read valid, one cycle after mem_rd_en.
REQ-023 All memory-side outputs SHALL be driven from flops.

Function
REQ-024 At most one of mem_rd_en/mem_wr_en SHALL be high in any cycle.
REQ-025 A grant in cycle T SHALL appear as the memory strobe with its address/data in cycle T+1.
REQ-026 rd_data/rd_valid SHALL be registered from mem_data_out/mem_valid_out. Read latency is rd_gnt at T to rd_valid at T+3.
REQ-027 FSM states: ARB and FILL.
  - ARB: the pending write is the client write.
  - FILL: the pending write is the fill write; wr_gnt SHALL be 0.
REQ-028 Priority: reads win over writes, subject to REQ-029.
REQ-029 starve_cnt:
  - Increments on each read grant while a write is pending.
  - Clears on any write grant, or when no write is pending.
  - When starve_cnt == STARVE_LIMIT and a write is pending, the write SHALL be granted and rd_gnt SHALL be 0.
REQ-030 ARB -> FILL on fill_start.
  - fill_color is latched and the 14-bit fill counter is cleared.
  - fill_busy rises the next cycle.
  - A client write granted in the same cycle SHALL still complete.
REQ-031 fill_start in FILL SHALL be ignored.
REQ-032 Fill write addressing: x = cnt[6:0], y = cnt[13:7]. The counter increments only on a fill-write grant.
REQ-033 FILL -> ARB on the grant of the write with cnt == 16383. fill_busy SHALL be 0 from the following cycle.

Reset
REQ-034 On rst_n low, all outputs SHALL be 0 immediately, and FSM, starve_cnt and fill counter SHALL reset to ARB/0/0.
REQ-035 Reset during FILL SHALL abort the fill with no further memory writes.
REQ-036 Reads in flight during reset SHALL be dropped with no rd_valid.

Structure
REQ-037 Package framebuffer_pkg SHALL hold FB_W=128, FB_H=128, COORD_W=7, PIXEL_W=16, FB_PIXELS=16384, and the state enum {ARB, FILL}.
REQ-038 Sub-module fb_fill_counter (14-bit counter, advance, last flag, x/y split) SHALL be used. Arbitration logic SHALL remain in this module.

Verification
REQ-039 Read (5,9) with memory returning 16'h1234 -> rd_gnt at T, mem_rd_en with addr (5,9) at T+1, rd_valid with 16'h1234 at T+3.
REQ-040 wr_req (127,127, 16'hF800) with rd_req idle -> wr_gnt same cycle; mem_wr_en at T+1 with that address and data.
REQ-041 rd_req held high and wr_req high, STARVE_LIMIT=4 -> grant pattern R,R,R,R,W,R...; mem strobes are never simultaneous.
REQ-042 fill_start with color 16'h001F, no reads -> 16384 consecutive writes covering (0,0)..(127,127) in x-fastest order; fill_busy low the cycle after the last write; wr_gnt 0 throughout.
REQ-043 rst_n pulsed low at fill count 100 -> mem_wr_en drops immediately; fill_busy 0; no writes after reset until a new request.
REQ-044 fill_start and wr_req in the same ARB cycle -> client write issued; fill begins with (0,0) next; fill_start during FILL ignored (counter not restarted).
